// File: rtl/sel3_debounce_if.sv
// Purpose : bundles the switch inputs and debounced select outputs of sel3_debounce.
// Latency : n/a (signal bundle only).
// Backpressure: none; the outputs are level signals plus a one-cycle change strobe.
// Ports:
//   sw_raw  [2:0] raw asynchronous switches (bit 2 -> S1, bit 1 -> S2, bit 0 -> S3)
//   S1/S2/S3      debounced select lines to the decoder stage
//   sel     [2:0] {S1,S2,S3}
//   sel_chg       one-cycle pulse aligned with a new sel value
//   settled       high when no channel is mid-settle
interface sel3_debounce_if;
    logic [2:0] sw_raw;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [2:0] sel;
    logic       sel_chg;
    logic       settled;

    // master: the switch source / downstream consumer side
    modport master (
        output sw_raw,
        input  S1, S2, S3, sel, sel_chg, settled
    );

    // slave: the debouncer itself
    modport slave (
        input  sw_raw,
        output S1, S2, S3, sel, sel_chg, settled
    );
endinterface

// File: rtl/sel3_debounce.sv
// Purpose : 2-flop synchronise and debounce three slide switches into decoder selects.
// Latency : raw change first captured at edge k is committed at edge k+1+STABLE_CNT.
// Backpressure: none; sel_chg pulses one cycle per commit edge, settled flags clean codes.
// Ports:
//   clk   system clock, all state on rising edge
//   rst_n synchronous active-low reset
//   io    sel3_debounce_if.slave (sw_raw in; S1..S3, sel, sel_chg, settled out)
module sel3_debounce #(
    parameter int unsigned STABLE_CNT = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    sel3_debounce_if.slave  io
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } ch_state_t;

    // Counter value on which the final differing sample commits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       committed;
    ch_state_t        state [3];
    logic [CNT_W-1:0] cnt   [3];
    logic             sel_chg_q;
    logic [2:0]       commit;
    logic             settled_c;

    // A channel commits when it has been settling and this is the
    // STABLE_CNT-th consecutive edge on which sync2 differs.
    always_comb begin
        commit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (state[i] == ST_SETTLING && sync2[i] != committed[i] && cnt[i] == CNT_LAST) begin
                commit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 3'b000;
            sync2     <= 3'b000;
            committed <= 3'b000;
            sel_chg_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1 <= io.sw_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    ST_STABLE: begin
                        if (sync2[i] != committed[i]) begin
                            state[i] <= ST_SETTLING;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    ST_SETTLING: begin
                        if (sync2[i] == committed[i]) begin
                            // glitch shorter than STABLE_CNT: drop it
                            state[i] <= ST_STABLE;
                            cnt[i]   <= '0;
                        end else if (commit[i]) begin
                            committed[i] <= sync2[i];
                            state[i]     <= ST_STABLE;
                            cnt[i]       <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= ST_STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
            // Any number of same-edge commits collapse into one pulse.
            sel_chg_q <= |commit;
        end
    end

    always_comb begin
        settled_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (state[i] != ST_STABLE) begin
                settled_c = 1'b0;
            end
        end
    end

    assign io.sel     = committed;
    assign io.S1      = committed[2];
    assign io.S2      = committed[1];
    assign io.S3      = committed[0];
    assign io.sel_chg = sel_chg_q;
    assign io.settled = settled_c;

endmodule

// File: tb/tb_sel3_debounce.sv
// Purpose : self-checking bench for sel3_debounce with STABLE_CNT=4, CNT_W=3.
// Latency : model commits a channel once its last STABLE_CNT synchronised samples all differ.
// Backpressure: n/a; inputs driven on falling edges, outputs checked on falling edges.
module tb_sel3_debounce;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n;

    sel3_debounce_if dif ();

    sel3_debounce #(
        .STABLE_CNT (SC),
        .CNT_W      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Sliding window of the last SC samples seen after the 2-flop sync.
    // A channel's output flips when every sample in its window disagrees
    // with the current output; it is settling while the newest sample disagrees.
    logic [2:0] m_s1, m_s2, m_com, m_last;
    logic [2:0] hist [SC];
    logic [2:0] m_mask;
    logic       m_chg;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1   = 3'b000;
            m_s2   = 3'b000;
            m_com  = 3'b000;
            m_last = 3'b000;
            m_chg  = 1'b0;
            for (int i = 0; i < SC; i++) hist[i] = 3'b000;
        end else begin
            for (int i = SC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_s2;
            m_last  = m_s2;
            m_mask  = 3'b111;
            for (int i = 0; i < SC; i++) m_mask = m_mask & (hist[i] ^ m_com);
            m_com = m_com ^ m_mask;
            m_chg = |m_mask;
            m_s2  = m_s1;
            m_s1  = dif.sw_raw;
        end
        m_valid = 1'b1;
    end

    // ---------------- checking ----------------
    int n_chk     = 0;
    int n_fail    = 0;
    int chg_total = 0;
    int c0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n cycles; on every falling edge compare the DUT against the model.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_sel",     dif.sel,     m_com);
                chk("model_S1",      dif.S1,      m_com[2]);
                chk("model_S2",      dif.S2,      m_com[1]);
                chk("model_S3",      dif.S3,      m_com[0]);
                chk("model_sel_chg", dif.sel_chg, m_chg);
                chk("model_settled", dif.settled, (m_last == m_com));
            end
            if (dif.sel_chg === 1'b1) chg_total++;
        end
    endtask

    initial begin
        // Reset held 3 cycles with all switches high
        rst_n      = 1'b0;
        dif.sw_raw = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_sel",     dif.sel,     3'b000);
            chk("rst_sel_chg", dif.sel_chg, 1'b0);
            chk("rst_settled", dif.settled, 1'b1);
        end
        rst_n = 1'b1;
        c0 = chg_total;
        step(5);
        chk("rel_sel_early", dif.sel,     3'b000);
        chk("rel_settling",  dif.settled, 1'b0);
        step(1);
        chk("rel_sel",       dif.sel,     3'b111);
        chk("rel_chg",       dif.sel_chg, 1'b1);
        chk("rel_settled",   dif.settled, 1'b1);
        step(1);
        chk("rel_chg_drop",  dif.sel_chg, 1'b0);
        chk("rel_pulses",    chg_total - c0, 1);

        // Back to 000, then clean step to 101
        dif.sw_raw = 3'b000;
        step(10);
        chk("zero_sel", dif.sel, 3'b000);
        dif.sw_raw = 3'b101;
        c0 = chg_total;
        step(2);
        chk("step_settled_hold", dif.settled, 1'b1);
        step(1);
        chk("step_settled_drop", dif.settled, 1'b0);
        chk("step_sel_old",      dif.sel,     3'b000);
        step(2);
        chk("step_sel_late",     dif.sel,     3'b000);
        step(1);
        chk("step_sel",          dif.sel,     3'b101);
        chk("step_S1",           dif.S1,      1'b1);
        chk("step_S2",           dif.S2,      1'b0);
        chk("step_S3",           dif.S3,      1'b1);
        chk("step_chg",          dif.sel_chg, 1'b1);
        chk("step_settled",      dif.settled, 1'b1);
        step(1);
        chk("step_chg_drop",     dif.sel_chg, 1'b0);
        chk("step_pulses",       chg_total - c0, 1);

        // Glitch on bit0 for 3 cycles, from 000
        dif.sw_raw = 3'b000;
        step(10);
        c0 = chg_total;
        dif.sw_raw = 3'b001;
        step(3);
        chk("glitch_settling", dif.settled, 1'b0);
        dif.sw_raw = 3'b000;
        step(10);
        chk("glitch_sel",     dif.sel,     3'b000);
        chk("glitch_settled", dif.settled, 1'b1);
        chk("glitch_pulses",  chg_total - c0, 0);

        // Simultaneous 000 -> 111
        c0 = chg_total;
        dif.sw_raw = 3'b111;
        step(5);
        chk("simul_sel_early", dif.sel, 3'b000);
        step(1);
        chk("simul_sel",       dif.sel,     3'b111);
        chk("simul_chg",       dif.sel_chg, 1'b1);
        step(4);
        chk("simul_pulses",    chg_total - c0, 1);

        // Staggered: bit2 at cycle 0, bit0 at cycle 2
        dif.sw_raw = 3'b000;
        step(10);
        c0 = chg_total;
        dif.sw_raw = 3'b100;
        step(2);
        dif.sw_raw = 3'b101;
        step(4);
        chk("stag_sel1",     dif.sel,     3'b100);
        chk("stag_chg1",     dif.sel_chg, 1'b1);
        chk("stag_settled1", dif.settled, 1'b0);
        step(1);
        chk("stag_gap_chg",  dif.sel_chg, 1'b0);
        chk("stag_gap_set",  dif.settled, 1'b0);
        step(1);
        chk("stag_sel2",     dif.sel,     3'b101);
        chk("stag_chg2",     dif.sel_chg, 1'b1);
        chk("stag_settled2", dif.settled, 1'b1);
        step(2);
        chk("stag_pulses",   chg_total - c0, 2);

        // Full sweep 0..7 from a fresh reset
        rst_n      = 1'b0;
        dif.sw_raw = 3'b000;
        step(2);
        rst_n = 1'b1;
        step(2);
        c0 = chg_total;
        for (int v = 0; v < 8; v++) begin
            dif.sw_raw = 3'(v);
            step(20);
            chk("sweep_sel", dif.sel, v);
        end
        chk("sweep_pulses", chg_total - c0, 7);

        // Reset mid-settle on the way to 101
        dif.sw_raw = 3'b000;
        step(10);
        dif.sw_raw = 3'b101;
        step(4);
        chk("mid_settling", dif.settled, 1'b0);
        c0 = chg_total;
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_sel",     dif.sel,     3'b000);
        chk("mid_rst_chg",     dif.sel_chg, 1'b0);
        chk("mid_rst_settled", dif.settled, 1'b1);
        rst_n = 1'b1;
        step(5);
        chk("mid_full_latency", dif.sel, 3'b000);
        step(1);
        chk("mid_commit",      dif.sel, 3'b101);
        chk("mid_pulses",      chg_total - c0, 1);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
